// File: rtl/booth_mac_pkg.sv
// rtl/booth_mac_pkg.sv - shared types and helpers for the radix-4 Booth MAC
package booth_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } mac_state_t;

  // Magnitude of a recoded Booth digit; the sign travels separately.
  typedef enum logic [1:0] {
    DIG_ZERO = 2'b00,
    DIG_ONE  = 2'b01,
    DIG_TWO  = 2'b10
  } dig_mag_t;

  localparam logic DIG_NEG = 1'b1;

  // Radix-4 digits needed to cover a W-bit operand extended to W+2 bits.
  function automatic int digit_count(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// rtl/booth_r4_digit_enc.sv - radix-4 Booth triplet recoder
module booth_r4_digit_enc
  import booth_mac_pkg::*;
(
  input  logic [2:0] triplet,
  output logic       sel1x,
  output logic       sel2x,
  output logic       neg
);

  dig_mag_t mag;

  // Map {b[2i+1], b[2i], b[2i-1]} to a signed digit in {-2..+2}.
  always_comb begin
    mag = DIG_ZERO;
    neg = 1'b0;
    unique case (triplet)
      3'b001, 3'b010: mag = DIG_ONE;
      3'b011:         mag = DIG_TWO;
      3'b100: begin
        mag = DIG_TWO;
        neg = DIG_NEG;
      end
      3'b101, 3'b110: begin
        mag = DIG_ONE;
        neg = DIG_NEG;
      end
      default:        mag = DIG_ZERO;
    endcase
  end

  assign sel1x = (mag == DIG_ONE);
  assign sel2x = (mag == DIG_TWO);

endmodule

// File: rtl/booth_r4_mac_seq.sv
// rtl/booth_r4_mac_seq.sv - iterative radix-4 Booth multiply-accumulate unit
module booth_r4_mac_seq
  import booth_mac_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 2 * W + 8,
  parameter int SAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             is_signed,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             overflow
);

  localparam int D  = digit_count(W);
  localparam int XW = W + 2;
  localparam int PW = 2 * W + 4;
  localparam int CW = $clog2(D + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  mac_state_t state_q, state_d;

  // Multiplicand pre-shifted to the weight of the current digit.
  logic [PW-1:0]    a_sh_q, a_sh_d;
  // {b_ext, b[-1]} shifted right two bits per digit; [2:0] is the live triplet.
  logic [XW:0]      b_sh_q, b_sh_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             clr_q, clr_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             sel1x, sel2x, neg;
  logic [XW-1:0]    a_ext, b_ext;
  logic [PW-1:0]    mag, addend;
  logic [ACC_W-1:0] p_ext, base, sum;
  logic             ovf_now;

  booth_r4_digit_enc u_enc (
    .triplet (b_sh_q[2:0]),
    .sel1x   (sel1x),
    .sel2x   (sel2x),
    .neg     (neg)
  );

  assign accept = in_valid & in_ready;
  assign a_ext  = {{2{is_signed & a[W-1]}}, a};
  assign b_ext  = {{2{is_signed & b[W-1]}}, b};

  // Negative digits use one's complement here; the +1 is the carry-in below.
  assign mag    = sel2x ? {a_sh_q[PW-2:0], 1'b0} : (sel1x ? a_sh_q : '0);
  assign addend = neg ? ~mag : mag;

  // Bring the product to accumulator width (sign-extend or drop redundant sign bits).
  if (ACC_W > PW) begin : g_p_wide
    assign p_ext = {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
  end else if (ACC_W == PW) begin : g_p_equal
    assign p_ext = prod_q;
  end else begin : g_p_narrow
    assign p_ext = prod_q[ACC_W-1:0];
  end

  assign base    = clr_q ? '0 : acc_q;
  assign sum     = base + p_ext;
  assign ovf_now = (base[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (cnt_q == CW'(D - 1)) state_d = ACC;
      ACC:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next values: capture, digit iteration and accumulate.
  always_comb begin
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    clr_d      = clr_q;
    acc_d      = acc_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_sh_d = {{(PW-XW){a_ext[XW-1]}}, a_ext};
          b_sh_d = {b_ext, 1'b0};
          prod_d = '0;
          cnt_d  = '0;
          en_d   = acc_en;
          clr_d  = acc_clr;
          if (acc_clr) overflow_d = 1'b0;
        end
      end
      CALC: begin
        prod_d = prod_q + addend + {{(PW-1){1'b0}}, neg};
        a_sh_d = {a_sh_q[PW-3:0], 2'b00};
        b_sh_d = {2'b00, b_sh_q[XW:2]};
        cnt_d  = cnt_q + CW'(1);
      end
      ACC: begin
        if (en_q) begin
          if (ovf_now && (SAT != 0)) acc_d = base[ACC_W-1] ? ACC_MIN : ACC_MAX;
          else                       acc_d = sum;
          overflow_d = overflow_q | ovf_now;
          result_d   = acc_d;
        end else begin
          result_d = p_ext;
          if (clr_q) acc_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      clr_q      <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      clr_q      <= clr_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_booth_r4_mac_seq.sv
// tb/tb_booth_r4_mac_seq.sv - directed vector bench for booth_r4_mac_seq
module tb_booth_r4_mac_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        is_signed = 1'b0;
  logic        acc_en = 1'b0;
  logic        acc_clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready0, in_ready1, in_ready2;
  logic        out_valid0, out_valid1, out_valid2;
  logic [23:0] result0;
  logic [15:0] result1, result2;
  logic        overflow0, overflow1, overflow2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  booth_r4_mac_seq #(.W(8), .ACC_W(24), .SAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .overflow(overflow0)
  );

  booth_r4_mac_seq #(.W(8), .ACC_W(16), .SAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .result(result1), .overflow(overflow1)
  );

  booth_r4_mac_seq #(.W(8), .ACC_W(16), .SAT(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .is_signed(is_signed), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .overflow(overflow2)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic        en;
    logic        clr;
    logic [23:0] e0;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        o0;
    logic        o1;
    logic        o2;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Present one transaction at posedge+1, then wait (bounded) for out_valid.
  task automatic start_txn(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                           input logic ten, input logic tclr, output int lat);
    chk("in_ready_before_accept", {31'd0, in_ready0}, 32'd1);
    a = ta; b = tb; is_signed = ts; acc_en = ten; acc_clr = tclr; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    is_signed = 1'($urandom); acc_en = 1'($urandom); acc_clr = 1'($urandom);
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_txn(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, {31'd0, out_valid0}, 32'd0);
    chk({tag, "_in_ready_back"}, {31'd0, in_ready0}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;

    //          a       b      s     en    clr   e0 (24b)     e1 (16b,sat)  e2 (16b,wrap) o0 o1 o2
    vecs[0]  = '{8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 24'h004000, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 24'h00FE01, 16'hFE01, 16'hFE01, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 24'h000001, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h03, 8'h05, 1'b1, 1'b1, 1'b1, 24'h00000F, 16'h000F, 16'h000F, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'hFD, 8'h05, 1'b1, 1'b1, 1'b0, 24'h000000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'hF9, 8'h09, 1'b1, 1'b1, 1'b0, 24'hFFFFC1, 16'hFFC1, 16'hFFC1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'h80, 8'h80, 1'b1, 1'b1, 1'b1, 24'h004000, 16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h80, 8'h80, 1'b1, 1'b1, 1'b0, 24'h008000, 16'h7FFF, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 24'h000000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{8'hFF, 8'h80, 1'b0, 1'b0, 1'b0, 24'h007F80, 16'h7F80, 16'h7F80, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 24'hFFC080, 16'hC080, 16'hC080, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 24'h000001, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h02, 8'h03, 1'b1, 1'b1, 1'b0, 24'h000006, 16'h0006, 16'h0006, 1'b0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready0}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("reset_result", {8'd0, result0}, 32'd0);
    chk("reset_overflow", {31'd0, overflow0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      start_txn(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].en, vecs[i].clr, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd6);
      chk($sformatf("v%0d_result0", i), {8'd0, result0}, {8'd0, vecs[i].e0});
      chk($sformatf("v%0d_result1", i), {16'd0, result1}, {16'd0, vecs[i].e1});
      chk($sformatf("v%0d_result2", i), {16'd0, result2}, {16'd0, vecs[i].e2});
      chk($sformatf("v%0d_overflow0", i), {31'd0, overflow0}, {31'd0, vecs[i].o0});
      chk($sformatf("v%0d_overflow1", i), {31'd0, overflow1}, {31'd0, vecs[i].o1});
      chk($sformatf("v%0d_overflow2", i), {31'd0, overflow2}, {31'd0, vecs[i].o2});
      finish_txn($sformatf("v%0d", i));
    end

    // Backpressure: 7 * -6 = -42 held while a competing request is offered.
    start_txn(8'h07, 8'hFA, 1'b1, 1'b0, 1'b0, lat);
    chk("bp_latency", lat, 32'd6);
    chk("bp_result", {8'd0, result0}, 32'h00FFFFD6);
    in_valid = 1'b1; a = 8'h09; b = 8'h09; is_signed = 1'b1; acc_en = 1'b1; acc_clr = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_result", c), {8'd0, result0}, 32'h00FFFFD6);
      chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready0}, 32'd0);
      chk($sformatf("bp%0d_out_valid", c), {31'd0, out_valid0}, 32'd1);
    end
    in_valid = 1'b0;
    finish_txn("bp");
    @(posedge clk); #1;
    chk("bp_no_stale_accept", {31'd0, in_ready0}, 32'd1);

    // Reset during the third CALC cycle of 5 * 5.
    a = 8'h05; b = 8'h05; is_signed = 1'b1; acc_en = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_calc_busy", {31'd0, in_ready0}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_result", {8'd0, result0}, 32'd0);
    chk("abort_out_valid", {31'd0, out_valid0}, 32'd0);
    chk("abort_overflow", {31'd0, overflow0}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready0}, 32'd1);
    @(posedge clk); #5;
    rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid0) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_partial_result", seen, 32'd0);

    // out_ready held high throughout must not disturb the transaction.
    out_ready = 1'b1;
    start_txn(8'h02, 8'h03, 1'b1, 1'b1, 1'b0, lat);
    chk("post_reset_latency", lat, 32'd6);
    chk("post_reset_result", {8'd0, result0}, 32'd6);
    @(posedge clk); #1;
    chk("post_reset_drop", {31'd0, out_valid0}, 32'd0);
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
